// File: rtl/fetch_predict_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_predict_unit: dual-issue fetch with gshare + BTB prediction         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_predict_unit #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [7:0]  imem_addr0,
  output logic [7:0]  imem_addr1,
  input  logic [31:0] imem_data0,
  input  logic [31:0] imem_data1,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic [4:0]  redirect_ghr,
  input  logic        upd_valid,
  input  logic [7:0]  upd_pc,
  input  logic [4:0]  upd_ghr,
  input  logic        upd_taken,
  input  logic [7:0]  upd_target,
  output logic [31:0] first_F,
  output logic [31:0] second_F,
  output logic        first_branch_F,
  output logic        second_branch_F,
  output logic        first_prediction_F,
  output logic        second_prediction_F,
  output logic [7:0]  first_target_addr_F,
  output logic [7:0]  second_target_addr_F,
  output logic [7:0]  first_next_addr_F,
  output logic [7:0]  second_next_addr_F,
  output logic [4:0]  ghr_F,
  output logic        second_flush
);

  localparam int PHT_DEPTH = 32;
  localparam int BTB_DEPTH = 16;
  localparam logic [1:0] PHT_INIT = 2'b01;

  logic [7:0] pc;
  logic [4:0] ghr;
  logic [1:0] pht        [PHT_DEPTH];
  logic       btb_valid  [BTB_DEPTH];
  logic [3:0] btb_tag    [BTB_DEPTH];
  logic [7:0] btb_target [BTB_DEPTH];

  logic [7:0] pc1, pc2;
  logic       hit0, hit1, pred0, pred1;
  logic [7:0] tgt0, tgt1;
  logic [4:0] pht_idx0, pht_idx1, upd_idx;
  logic [7:0] next_pc;
  logic [4:0] next_ghr;

  assign pc1 = pc + 8'd1;
  assign pc2 = pc + 8'd2;
  assign imem_addr0 = pc;
  assign imem_addr1 = pc1;

  // Both slots index the PHT with the unshifted GHR
  assign pht_idx0 = pc[4:0] ^ ghr;
  assign pht_idx1 = pc1[4:0] ^ ghr;
  assign upd_idx  = upd_pc[4:0] ^ upd_ghr;

  always_comb begin
    hit0  = btb_valid[pc[3:0]] && (btb_tag[pc[3:0]] == pc[7:4]);
    hit1  = btb_valid[pc1[3:0]] && (btb_tag[pc1[3:0]] == pc1[7:4]);
    pred0 = hit0 && pht[pht_idx0][1];
    pred1 = hit1 && pht[pht_idx1][1];
    tgt0  = hit0 ? btb_target[pc[3:0]] : 8'd0;
    tgt1  = hit1 ? btb_target[pc1[3:0]] : 8'd0;
  end

  always_comb begin
    next_pc = pc2;
    if (pred0)
      next_pc = tgt0;
    else if (pred1)
      next_pc = tgt1;
  end

  // A not-taken slot-1 branch shifts in 0 before slot 2's outcome
  always_comb begin
    next_ghr = ghr;
    if (pred0)
      next_ghr = {ghr[3:0], 1'b1};
    else if (hit0)
      next_ghr = hit1 ? {ghr[2:0], 1'b0, pred1} : {ghr[3:0], 1'b0};
    else if (hit1)
      next_ghr = {ghr[3:0], pred1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      ghr <= 5'd0;
    end else if (redirect_valid) begin
      pc  <= redirect_pc;
      ghr <= redirect_ghr;
    end else if (!stall) begin
      pc  <= next_pc;
      ghr <= next_ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++)
        pht[i] <= PHT_INIT;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= 4'd0;
        btb_target[i] <= 8'd0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (pht[upd_idx] != 2'b11)
          pht[upd_idx] <= pht[upd_idx] + 2'd1;
        btb_valid[upd_pc[3:0]]  <= 1'b1;
        btb_tag[upd_pc[3:0]]    <= upd_pc[7:4];
        btb_target[upd_pc[3:0]] <= upd_target;
      end else if (pht[upd_idx] != 2'b00) begin
        pht[upd_idx] <= pht[upd_idx] - 2'd1;
      end
    end
  end

  // The redirect cycle presents a NOP bundle with slot 2 squashed
  always_comb begin
    first_F              = imem_data0;
    second_F             = imem_data1;
    first_branch_F       = hit0;
    second_branch_F      = hit1;
    first_prediction_F   = pred0;
    second_prediction_F  = pred1;
    first_target_addr_F  = tgt0;
    second_target_addr_F = tgt1;
    first_next_addr_F    = pc1;
    second_next_addr_F   = pc2;
    second_flush         = pred0;
    if (redirect_valid) begin
      first_F              = 32'd0;
      second_F             = 32'd0;
      first_branch_F       = 1'b0;
      second_branch_F      = 1'b0;
      first_prediction_F   = 1'b0;
      second_prediction_F  = 1'b0;
      first_target_addr_F  = 8'd0;
      second_target_addr_F = 8'd0;
      first_next_addr_F    = 8'd0;
      second_next_addr_F   = 8'd0;
      second_flush         = 1'b1;
    end
  end

  assign ghr_F = ghr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
`default_nettype none
// Directed bench for fetch_predict_unit: reset, BTB/PHT training, redirect,
// stall, PC wrap, counter saturation and mid-run reset.
module tb_fetch_predict_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [7:0]  imem_addr0, imem_addr1;
  logic [31:0] imem_data0, imem_data1;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [4:0]  redirect_ghr;
  logic        upd_valid, upd_taken;
  logic [7:0]  upd_pc, upd_target;
  logic [4:0]  upd_ghr;
  logic [31:0] first_F, second_F;
  logic        first_branch_F, second_branch_F;
  logic        first_prediction_F, second_prediction_F;
  logic [7:0]  first_target_addr_F, second_target_addr_F;
  logic [7:0]  first_next_addr_F, second_next_addr_F;
  logic [4:0]  ghr_F;
  logic        second_flush;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [7:0] a);
    return {a, ~a, 8'h3C, a ^ 8'h5A};
  endfunction

  assign imem_data0 = mem(imem_addr0);
  assign imem_data1 = mem(imem_addr1);

  fetch_predict_unit #(.RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
    .imem_data0(imem_data0), .imem_data1(imem_data1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ghr(redirect_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .first_F(first_F), .second_F(second_F),
    .first_branch_F(first_branch_F), .second_branch_F(second_branch_F),
    .first_prediction_F(first_prediction_F), .second_prediction_F(second_prediction_F),
    .first_target_addr_F(first_target_addr_F), .second_target_addr_F(second_target_addr_F),
    .first_next_addr_F(first_next_addr_F), .second_next_addr_F(second_next_addr_F),
    .ghr_F(ghr_F), .second_flush(second_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [7:0] p, input logic [4:0] g);
    redirect_valid = 1'b1; redirect_pc = p; redirect_ghr = g;
  endtask

  task automatic train(input logic [7:0] p, input logic [4:0] g, input logic t, input logic [7:0] tg);
    upd_valid = 1'b1; upd_pc = p; upd_ghr = g; upd_taken = t; upd_target = tg;
  endtask

  task automatic idle();
    stall = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0; redirect_ghr = 5'd0;
    upd_valid = 1'b0; upd_pc = 8'd0; upd_ghr = 5'd0; upd_taken = 1'b0; upd_target = 8'd0;
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_addr0", imem_addr0, 8'h00);
    chk("rst_addr1", imem_addr1, 8'h01);
    chk("rst_first_F", first_F, mem(8'h00));
    chk("rst_second_F", second_F, mem(8'h01));
    chk("rst_flags", {first_branch_F, second_branch_F, first_prediction_F, second_prediction_F, second_flush}, 5'b0);
    chk("rst_targets", {first_target_addr_F, second_target_addr_F}, 16'h0000);
    chk("rst_next", {first_next_addr_F, second_next_addr_F}, 16'h0102);
    chk("rst_ghr", ghr_F, 5'd0);

    // Straight-line fetch advances by two
    tick(); chk("seq_pc2", imem_addr0, 8'h02);
    tick(); chk("seq_pc4", imem_addr0, 8'h04);
    tick(); chk("seq_pc6", imem_addr0, 8'h06);
    chk("seq_ghr", ghr_F, 5'd0);
    chk("seq_flush", second_flush, 1'b0);

    // Train 0x10 taken -> 0x40 twice (PHT[16]: 01->10->11)
    train(8'h10, 5'd0, 1'b1, 8'h40);
    tick(); tick();
    idle();
    redirect(8'h10, 5'd0);
    #1;
    chk("redir_first_F", first_F, 32'd0);
    chk("redir_second_F", second_F, 32'd0);
    chk("redir_flush", second_flush, 1'b1);
    tick(); idle(); #1;
    chk("tk_pc", imem_addr0, 8'h10);
    chk("tk_branch", first_branch_F, 1'b1);
    chk("tk_pred", first_prediction_F, 1'b1);
    chk("tk_target", first_target_addr_F, 8'h40);
    chk("tk_flush", second_flush, 1'b1);
    chk("tk_slot2_branch", second_branch_F, 1'b0);
    tick();
    chk("tk_next_pc", imem_addr0, 8'h40);
    chk("tk_ghr", ghr_F, 5'b00001);

    // Slot-2 hit with weakly-not-taken counter; trained index differs from lookup
    redirect(8'h20, 5'b00011);
    train(8'h21, 5'h10, 1'b1, 8'h60);
    #1;
    chk("redir2_flags", {first_branch_F, second_branch_F, first_prediction_F, second_prediction_F}, 4'b0);
    chk("redir2_target", first_target_addr_F, 8'h00);
    tick(); idle(); #1;
    chk("s2_pc", imem_addr0, 8'h20);
    chk("s2_branch", second_branch_F, 1'b1);
    chk("s2_pred", second_prediction_F, 1'b0);
    chk("s2_target", second_target_addr_F, 8'h60);
    chk("s2_first_branch", first_branch_F, 1'b0);
    chk("s2_flush", second_flush, 1'b0);
    chk("s2_next", {first_next_addr_F, second_next_addr_F}, 16'h2122);
    chk("s2_ghr_before", ghr_F, 5'b00011);
    tick();
    chk("s2_next_pc", imem_addr0, 8'h22);
    chk("s2_ghr_after", ghr_F, 5'b00110);

    // Redirect wins over stall
    stall = 1'b1;
    redirect(8'h80, 5'b10101);
    #1;
    chk("sr_first_F", first_F, 32'd0);
    chk("sr_second_F", second_F, 32'd0);
    chk("sr_flush", second_flush, 1'b1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("sr_pc", imem_addr0, 8'h80);
    chk("sr_ghr", ghr_F, 5'b10101);
    tick();
    chk("stall_hold_pc", imem_addr0, 8'h80);
    chk("stall_hold_ghr", ghr_F, 5'b10101);
    idle();

    // PC wrap at 0xFF
    redirect(8'hFF, 5'd0);
    tick(); idle(); #1;
    chk("wrap_addr1", imem_addr1, 8'h00);
    chk("wrap_second_F", second_F, mem(8'h00));
    chk("wrap_next", {first_next_addr_F, second_next_addr_F}, 16'h0001);
    tick();
    chk("wrap_next_pc", imem_addr0, 8'h01);

    // Saturation: 4 taken (01->10->11->11->11), 1 not-taken -> 10
    train(8'h35, 5'd0, 1'b1, 8'h77);
    tick(); tick(); tick(); tick();
    upd_taken = 1'b0;
    redirect(8'h35, 5'd0);
    tick(); idle(); #1;
    chk("sat_branch", first_branch_F, 1'b1);
    chk("sat_pred", first_prediction_F, 1'b1);
    chk("sat_target", first_target_addr_F, 8'h77);
    chk("sat_flush", second_flush, 1'b1);
    // Another not-taken -> 01; BTB entry stays valid
    train(8'h35, 5'd0, 1'b0, 8'h00);
    redirect(8'h35, 5'd0);
    tick(); idle(); #1;
    chk("dec_pred", first_prediction_F, 1'b0);
    chk("dec_branch", first_branch_F, 1'b1);
    chk("dec_flush", second_flush, 1'b0);
    chk("dec_ghr", ghr_F, 5'd0);

    // Reset beats redirect, stall and training
    rst = 1'b1; stall = 1'b1;
    redirect(8'h99, 5'b11111);
    train(8'h00, 5'd0, 1'b1, 8'h11);
    tick();
    rst = 1'b0; idle(); #1;
    chk("mrst_pc", imem_addr0, 8'h00);
    chk("mrst_ghr", ghr_F, 5'd0);
    chk("mrst_branch", first_branch_F, 1'b0);
    chk("mrst_flush", second_flush, 1'b0);
    redirect(8'h35, 5'd0);
    tick(); idle(); #1;
    chk("mrst_btb_clear", first_branch_F, 1'b0);
    chk("mrst_next_pc_after", first_next_addr_F, 8'h36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
